pipe_field_engine: RTL and testbench



---
 rtl/pipe_field_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_pipe_field_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_field_engine.sv
// Playfield engine: bird vertical physics, scrolling pipe channels with
// optional gap oscillation, and a saturating three-digit BCD score.
module pipe_field_engine #(
   parameter int unsigned NUM_PIPES  = 3,
   parameter int unsigned SCREEN_W   = 640,
   parameter int unsigned SCREEN_H   = 480,
   parameter int unsigned PIPE_W     = 45,
   parameter int unsigned GAP_H      = 100,
   parameter int unsigned PIPE_X0    = 350,
   parameter int unsigned PIPE_PITCH = 228,
   parameter int unsigned BIRD_X     = 135,
   parameter int unsigned BIRD_H     = 25,
   parameter int unsigned BIRD_Y0    = 215,
   parameter int unsigned GRAVITY    = 1,
   parameter int unsigned JUMP_VEL   = 6,
   parameter int unsigned MAX_FALL   = 8
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     tick_bird,
   input  logic                     tick_pipe,
   input  logic                     flap,
   input  logic                     osc_mode,
   input  logic                     hit,
   input  logic [8:0]               rand_in,
   output logic [8:0]               bird_y,
   output logic [10*NUM_PIPES-1:0]  pipe_x,
   output logic [6*NUM_PIPES-1:0]   pipe_w,
   output logic [9*NUM_PIPES-1:0]   pipe_gap_y,
   output logic [1:0]               state,
   output logic [11:0]              score
);
   localparam int unsigned Y_MAX    = SCREEN_H - BIRD_H;
   localparam int unsigned GAP_MAX  = SCREEN_H - GAP_H;
   localparam int unsigned GAP_INIT = GAP_MAX / 2;
   localparam int          PASS_X   = int'(BIRD_X) - int'(PIPE_W);

   localparam logic signed [10:0] Y_MAX_S    = 11'(Y_MAX);
   localparam logic signed [6:0]  GRAV_S     = 7'(GRAVITY);
   localparam logic signed [6:0]  MAX_FALL_S = 7'(MAX_FALL);
   localparam logic [5:0]         JUMP_NEG   = 6'(64 - JUMP_VEL);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DEAD = 2'b10
   } state_t;

   state_t state_q, state_d;
   logic   run, start, restart;

   logic [8:0]           y_q, y_d;
   logic [5:0]           vel_q, vel_d;
   logic                 pend_q;
   logic signed [10:0]   y_sum;
   logic signed [6:0]    vel_inc;
   logic [11:0]          score_q, score_inc;
   logic [NUM_PIPES-1:0] pass;

   // State register
   always_ff @(posedge clk or posedge clr) begin
      if (clr) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state and control strobes
   always_comb begin
      state_d = state_q;
      run     = 1'b0;
      start   = 1'b0;
      restart = 1'b0;
      case (state_q)
         S_IDLE: begin
            start = flap;
            if (flap) state_d = S_RUN;
         end
         S_RUN: begin
            run = 1'b1;
            if (hit || (y_q == 9'(Y_MAX))) state_d = S_DEAD;
         end
         S_DEAD: begin
            restart = flap;
            if (flap) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bird position clamp and velocity update
   always_comb begin
      y_sum   = $signed({2'b00, y_q}) + $signed({{5{vel_q[5]}}, vel_q});
      vel_inc = $signed({vel_q[5], vel_q}) + GRAV_S;
      y_d     = y_sum[8:0];
      if (y_sum < 11'sd0)        y_d = '0;
      else if (y_sum > Y_MAX_S)  y_d = 9'(Y_MAX);
      vel_d = vel_inc[5:0];
      if (pend_q || flap)              vel_d = JUMP_NEG;
      else if (vel_inc > MAX_FALL_S)   vel_d = MAX_FALL_S[5:0];
   end

   // Bird registers; a flap coinciding with tick_bird acts as pending
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         y_q    <= 9'(BIRD_Y0);
         vel_q  <= '0;
         pend_q <= 1'b0;
      end else if (restart) begin
         y_q    <= 9'(BIRD_Y0);
         vel_q  <= '0;
         pend_q <= 1'b0;
      end else if (run) begin
         if (tick_bird) begin
            y_q    <= y_d;
            vel_q  <= vel_d;
            pend_q <= 1'b0;
         end else if (flap) begin
            pend_q <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
      localparam logic [9:0] X_INIT   = 10'(PIPE_X0 + i * PIPE_PITCH);
      localparam logic       DIR_INIT = 1'(i % 2);

      logic [9:0] x_q, x_d;
      logic [5:0] w_q, w_d;
      logic [8:0] g_q, g_d;
      logic       dn_q, dn_d;
      logic       respawn;

      // Scroll, shrink, respawn and gap oscillation for one channel
      always_comb begin
         x_d     = x_q;
         w_d     = w_q;
         g_d     = g_q;
         dn_d    = dn_q;
         respawn = (x_q == '0) && (w_q == '0);
         if (x_q != '0) begin
            x_d = x_q - 10'd1;
         end else if (w_q != '0) begin
            w_d = w_q - 6'd1;
         end else begin
            x_d = 10'(SCREEN_W);
            w_d = 6'(PIPE_W);
            g_d = (rand_in > 9'(GAP_MAX)) ? 9'(GAP_MAX) : rand_in;
         end
         if (osc_mode && !respawn) begin
            if (!dn_q) begin
               if (g_q == '0) begin
                  dn_d = 1'b1;
                  g_d  = 9'd1;
               end else begin
                  g_d = g_q - 9'd1;
               end
            end else begin
               if (g_q == 9'(GAP_MAX)) begin
                  dn_d = 1'b0;
                  g_d  = g_q - 9'd1;
               end else begin
                  g_d = g_q + 9'd1;
               end
            end
         end
      end

      // Channel registers, updated on tick_pipe while running
      always_ff @(posedge clk or posedge clr) begin
         if (clr) begin
            x_q  <= X_INIT;
            w_q  <= 6'(PIPE_W);
            g_q  <= 9'(GAP_INIT);
            dn_q <= DIR_INIT;
         end else if (restart) begin
            x_q  <= X_INIT;
            w_q  <= 6'(PIPE_W);
            g_q  <= 9'(GAP_INIT);
            dn_q <= DIR_INIT;
         end else if (run && tick_pipe) begin
            x_q  <= x_d;
            w_q  <= w_d;
            g_q  <= g_d;
            dn_q <= dn_d;
         end
      end

      assign pass[i]               = (PASS_X > 0) && (x_q == 10'(PASS_X));
      assign pipe_x[i*10 +: 10]    = x_q;
      assign pipe_w[i*6 +: 6]      = w_q;
      assign pipe_gap_y[i*9 +: 9]  = g_q;
   end

   // Saturating BCD increment of the score
   always_comb begin
      score_inc = score_q;
      if (score_q != 12'h999) begin
         if (score_q[3:0] != 4'd9) begin
            score_inc[3:0] = score_q[3:0] + 4'd1;
         end else begin
            score_inc[3:0] = 4'd0;
            if (score_q[7:4] != 4'd9) begin
               score_inc[7:4] = score_q[7:4] + 4'd1;
            end else begin
               score_inc[7:4]  = 4'd0;
               score_inc[11:8] = score_q[11:8] + 4'd1;
            end
         end
      end
   end

   // Score register: cleared on reset and on game start only
   always_ff @(posedge clk or posedge clr) begin
      if (clr)                           score_q <= '0;
      else if (start)                    score_q <= '0;
      else if (run && tick_pipe && |pass) score_q <= score_inc;
   end

   assign bird_y = y_q;
   assign state  = state_q;
   assign score  = score_q;
endmodule

// File: tb/tb_pipe_field_engine.sv
// Directed bench for pipe_field_engine: default-sized playfield plus a
// shrunken single-channel instance to reach score saturation quickly.
module tb_pipe_field_engine;
   logic        clk = 1'b0;
   logic        clr, tick_bird, tick_pipe, flap, osc_mode, hit;
   logic [8:0]  rand_in;
   logic [8:0]  bird_y;
   logic [29:0] pipe_x;
   logic [17:0] pipe_w;
   logic [26:0] pipe_gap_y;
   logic [1:0]  state;
   logic [11:0] score;

   logic        flap2, tp2, zero;
   logic [8:0]  rand2, y2, g2;
   logic [9:0]  x2;
   logic [5:0]  w2;
   logic [1:0]  st2;
   logic [11:0] sc2;

   int total = 0;
   int bad   = 0;
   int n;

   always #5 clk = ~clk;

   pipe_field_engine #(.NUM_PIPES(3)) u_dut (
      .clk(clk), .clr(clr), .tick_bird(tick_bird), .tick_pipe(tick_pipe),
      .flap(flap), .osc_mode(osc_mode), .hit(hit), .rand_in(rand_in),
      .bird_y(bird_y), .pipe_x(pipe_x), .pipe_w(pipe_w),
      .pipe_gap_y(pipe_gap_y), .state(state), .score(score)
   );

   pipe_field_engine #(
      .NUM_PIPES(1), .SCREEN_W(20), .PIPE_W(2), .PIPE_X0(15),
      .PIPE_PITCH(5), .BIRD_X(12)
   ) u_sat (
      .clk(clk), .clr(clr), .tick_bird(zero), .tick_pipe(tp2),
      .flap(flap2), .osc_mode(zero), .hit(zero), .rand_in(rand2),
      .bird_y(y2), .pipe_x(x2), .pipe_w(w2),
      .pipe_gap_y(g2), .state(st2), .score(sc2)
   );

   function automatic logic [9:0] px(input int i);
      return pipe_x[i*10 +: 10];
   endfunction
   function automatic logic [5:0] pw(input int i);
      return pipe_w[i*6 +: 6];
   endfunction
   function automatic logic [8:0] pg(input int i);
      return pipe_gap_y[i*9 +: 9];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr = 1'b1; tick_bird = 1'b0; tick_pipe = 1'b0; flap = 1'b0;
      osc_mode = 1'b0; hit = 1'b0; rand_in = 9'd0;
      flap2 = 1'b0; tp2 = 1'b0; zero = 1'b0; rand2 = 9'd0;
      repeat (2) cyc();
      clr = 1'b0;

      // reset values
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_bird", 32'(bird_y), 32'd215);
      chk("rst_x0", 32'(px(0)), 32'd350);
      chk("rst_x1", 32'(px(1)), 32'd578);
      chk("rst_x2", 32'(px(2)), 32'd806);
      chk("rst_w1", 32'(pw(1)), 32'd45);
      chk("rst_gap2", 32'(pg(2)), 32'd190);
      chk("rst_score", 32'(score), 32'd0);

      // nothing moves in IDLE without a flap
      tick_bird = 1'b1; tick_pipe = 1'b1; osc_mode = 1'b1; hit = 1'b1;
      repeat (3) cyc();
      tick_bird = 1'b0; tick_pipe = 1'b0; osc_mode = 1'b0; hit = 1'b0;
      chk("idle_state", 32'(state), 32'd0);
      chk("idle_x0", 32'(px(0)), 32'd350);
      chk("idle_bird", 32'(bird_y), 32'd215);
      chk("idle_gap0", 32'(pg(0)), 32'd190);

      flap = 1'b1; cyc(); flap = 1'b0;
      chk("run_state", 32'(state), 32'd1);

      // free fall: velocity 0..8 then capped at 8
      tick_bird = 1'b1; repeat (10) cyc(); tick_bird = 1'b0;
      chk("fall_y", 32'(bird_y), 32'd259);

      // pending flap consumed by next tick
      flap = 1'b1; cyc(); flap = 1'b0;
      tick_bird = 1'b1;
      cyc(); chk("flap_y1", 32'(bird_y), 32'd267);
      cyc(); chk("flap_y2", 32'(bird_y), 32'd261);
      tick_bird = 1'b0;

      // flap and tick in the same cycle
      flap = 1'b1; tick_bird = 1'b1; cyc(); flap = 1'b0;
      chk("same_y1", 32'(bird_y), 32'd256);
      cyc(); chk("same_y2", 32'(bird_y), 32'd250);
      tick_bird = 1'b0;

      // gap oscillation around both limits
      osc_mode = 1'b1; tick_pipe = 1'b1;
      repeat (188) cyc();
      chk("osc_g0_a", 32'(pg(0)), 32'd2);
      chk("osc_x0", 32'(px(0)), 32'd162);
      chk("osc_g1_a", 32'(pg(1)), 32'd378);
      cyc(); chk("osc_g0_b", 32'(pg(0)), 32'd1); chk("osc_g1_b", 32'(pg(1)), 32'd379);
      cyc(); chk("osc_g0_c", 32'(pg(0)), 32'd0); chk("osc_g1_c", 32'(pg(1)), 32'd380);
      cyc(); chk("osc_g0_d", 32'(pg(0)), 32'd1); chk("osc_g1_d", 32'(pg(1)), 32'd379);
      cyc(); chk("osc_g0_e", 32'(pg(0)), 32'd2); chk("osc_g1_e", 32'(pg(1)), 32'd378);
      chk("osc_g2_e", 32'(pg(2)), 32'd2);

      // scrolling, scoring, shrinking and respawn with gaps held
      osc_mode = 1'b0;
      repeat (68) cyc();
      chk("pre_pass_x0", 32'(px(0)), 32'd90);
      chk("pre_pass_score", 32'(score), 32'd0);
      cyc();
      chk("pass_x0", 32'(px(0)), 32'd89);
      chk("pass_score", 32'(score), 32'h001);
      repeat (89) cyc();
      chk("edge_x0", 32'(px(0)), 32'd0);
      chk("edge_w0", 32'(pw(0)), 32'd45);
      chk("hold_g0", 32'(pg(0)), 32'd2);
      chk("hold_g1", 32'(pg(1)), 32'd378);
      repeat (45) cyc();
      chk("shrunk_w0", 32'(pw(0)), 32'd0);
      chk("shrunk_x0", 32'(px(0)), 32'd0);
      rand_in = 9'd500;
      cyc();
      chk("spawn_x0", 32'(px(0)), 32'd640);
      chk("spawn_w0", 32'(pw(0)), 32'd45);
      chk("spawn_g0", 32'(pg(0)), 32'd380);
      chk("spawn_x1", 32'(px(1)), 32'd182);
      chk("spawn_score", 32'(score), 32'h001);

      // hit with simultaneous tick: update applied once, then DEAD
      hit = 1'b1; cyc(); hit = 1'b0; tick_pipe = 1'b0;
      chk("hit_state", 32'(state), 32'd2);
      chk("hit_x0", 32'(px(0)), 32'd639);
      chk("hit_x1", 32'(px(1)), 32'd181);
      chk("hit_x2", 32'(px(2)), 32'd409);
      tick_pipe = 1'b1; tick_bird = 1'b1; osc_mode = 1'b1;
      repeat (3) cyc();
      tick_pipe = 1'b0; tick_bird = 1'b0; osc_mode = 1'b0;
      chk("dead_state", 32'(state), 32'd2);
      chk("dead_x0", 32'(px(0)), 32'd639);
      chk("dead_bird", 32'(bird_y), 32'd250);
      chk("dead_g1", 32'(pg(1)), 32'd378);

      // DEAD -> IDLE reloads init values but keeps the score
      flap = 1'b1; cyc(); flap = 1'b0;
      chk("reidle_state", 32'(state), 32'd0);
      chk("reidle_bird", 32'(bird_y), 32'd215);
      chk("reidle_x0", 32'(px(0)), 32'd350);
      chk("reidle_g0", 32'(pg(0)), 32'd190);
      chk("reidle_score", 32'(score), 32'h001);
      flap = 1'b1; cyc(); flap = 1'b0;
      chk("rerun_state", 32'(state), 32'd1);
      chk("rerun_score", 32'(score), 32'd0);

      // fall to the floor
      n = 0;
      while (state != 2'b10 && n < 100) begin
         tick_bird = 1'b1; cyc(); n++;
      end
      tick_bird = 1'b0;
      chk("floor_state", 32'(state), 32'd2);
      chk("floor_y", 32'(bird_y), 32'd455);

      // asynchronous clear mid-run
      flap = 1'b1; cyc(); cyc(); flap = 1'b0;
      chk("clr_pre_state", 32'(state), 32'd1);
      tick_pipe = 1'b1; repeat (5) cyc(); tick_pipe = 1'b0;
      chk("clr_pre_x0", 32'(px(0)), 32'd345);
      #3 clr = 1'b1;
      #1;
      chk("clr_state", 32'(state), 32'd0);
      chk("clr_x0", 32'(px(0)), 32'd350);
      chk("clr_bird", 32'(bird_y), 32'd215);
      cyc(); clr = 1'b0;
      tick_pipe = 1'b1; tick_bird = 1'b1; repeat (3) cyc();
      tick_pipe = 1'b0; tick_bird = 1'b0;
      chk("post_clr_state", 32'(state), 32'd0);
      chk("post_clr_x0", 32'(px(0)), 32'd350);
      flap = 1'b1; cyc(); flap = 1'b0;
      chk("post_clr_run", 32'(state), 32'd1);

      // score saturation on the small playfield (23 ticks per pass)
      flap2 = 1'b1; cyc(); flap2 = 1'b0;
      chk("sat_run", 32'(st2), 32'd1);
      tp2 = 1'b1;
      n = 0;
      repeat (6) begin cyc(); n++; end
      chk("sat_first", 32'(sc2), 32'h001);
      repeat (23) begin cyc(); n++; end
      chk("sat_second", 32'(sc2), 32'h002);
      while (sc2 != 12'h999 && n < 30000) begin cyc(); n++; end
      chk("sat_ticks", 32'(n), 32'd22960);
      chk("sat_reach", 32'(sc2), 32'h999);
      repeat (23) cyc();
      tp2 = 1'b0;
      chk("sat_hold", 32'(sc2), 32'h999);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
